// File: rtl/wb_stage_dual_pkg.sv
// Shared layout for the dual-issue writeback stage: MEM bundle, lane fields,
// forwarding lanes and trace FIFO entries.
package wb_stage_dual_pkg;

  localparam int BUS_W      = 141;
  localparam int LANE_W     = 70;
  localparam int PC_LSB     = 38;
  localparam int WEN_BIT    = 37;
  localparam int DEST_LSB   = 32;
  localparam int RESULT_LSB = 0;
  localparam int FWD_LANE_W = 38;
  localparam int TRACE_W    = 70;

  // Field order mirrors the bus bit offsets above, so a cast unpacks a lane.
  typedef struct packed {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  dest;
    logic [31:0] result;
  } lane_t;

  typedef struct packed {
    logic  lane1_valid;
    lane_t lane1;
    lane_t lane0;
  } bundle_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] data;
  } trace_entry_t;

  // x0 is hardwired, so a write to it never reaches the regfile or bypass.
  function automatic logic lane_writes(lane_t l);
    return l.wen && (l.dest != 5'd0);
  endfunction

  function automatic trace_entry_t to_trace(lane_t l);
    trace_entry_t e;
    e.pc   = l.pc;
    e.we   = lane_writes(l);
    e.dest = l.dest;
    e.data = l.result;
    return e;
  endfunction

endpackage

// File: rtl/wb_stage_dual_trace.sv
// Two-push / one-pop trace FIFO. push1 is only meaningful together with push0;
// din0 is always the older entry.
module trace_fifo_2w1r
  import wb_stage_dual_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push0,
  input  logic                     push1,
  input  trace_entry_t             din0,
  input  trace_entry_t             din1,
  output logic                     pop,
  output trace_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  trace_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [1:0]       n_push;

  assign n_push = {1'b0, push0} + {1'b0, push1};
  assign pop    = (count != '0);
  assign head   = mem[head_ptr];

  always_ff @(posedge clk) begin
    if (push0) mem[tail_ptr] <= din0;
    if (push1) mem[tail_ptr + PTR_W'(push0)] <= din1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      tail_ptr <= tail_ptr + PTR_W'(n_push);
      head_ptr <= head_ptr + PTR_W'(pop);
      count    <= count + CNT_W'(n_push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/wb_stage_dual.sv
// Dual-issue writeback stage: retires a two-lane bundle to both regfile write
// ports, offers it as a bypass source, and serialises it onto the debug trace.
module wb_stage_dual
  import wb_stage_dual_pkg::*;
#(
  parameter int TRACE_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ms_to_ws_valid,
  input  logic [BUS_W-1:0]      ms_to_ws_bus,
  output logic                  ws_allowin,
  output logic                  rf_we_01,
  output logic [4:0]            rf_waddr_01,
  output logic [31:0]           rf_wdata_01,
  output logic                  rf_we_02,
  output logic [4:0]            rf_waddr_02,
  output logic [31:0]           rf_wdata_02,
  output logic [2*FWD_LANE_W-1:0] ws_fwd_bus,
  output logic [31:0]           debug_wb_pc,
  output logic [3:0]            debug_wb_rf_wen,
  output logic [4:0]            debug_wb_rf_wnum,
  output logic [31:0]           debug_wb_rf_wdata
);

  localparam int CNT_W = $clog2(TRACE_DEPTH) + 1;

  bundle_t          ws_bundle;
  logic             ws_valid;
  lane_t            lane0;
  lane_t            lane1;
  logic [1:0]       n_lanes;
  logic             ws_ready_go;
  logic             accept;
  logic             retire;
  logic             fifo_pop;
  trace_entry_t     fifo_head;
  logic [CNT_W-1:0] fifo_count;

  assign lane0   = ws_bundle.lane0;
  assign lane1   = ws_bundle.lane1;
  assign n_lanes = 2'd1 + {1'b0, ws_bundle.lane1_valid};

  // Free space is judged before this cycle's pop, which keeps the check cheap.
  assign ws_ready_go = (TRACE_DEPTH - int'(fifo_count)) >= int'(n_lanes);
  assign ws_allowin  = !ws_valid || ws_ready_go;
  assign accept      = ms_to_ws_valid && ws_allowin;
  assign retire      = ws_valid && ws_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid <= 1'b0;
    end else if (accept) begin
      ws_valid <= 1'b1;
    end else if (retire) begin
      ws_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) ws_bundle <= bundle_t'(ms_to_ws_bus);
  end

  // The regfile gives port 02 priority, so a shared dest lands lane1's value.
  assign rf_we_01    = retire && lane_writes(lane0);
  assign rf_waddr_01 = lane0.dest;
  assign rf_wdata_01 = lane0.result;
  assign rf_we_02    = retire && ws_bundle.lane1_valid && lane_writes(lane1);
  assign rf_waddr_02 = lane1.dest;
  assign rf_wdata_02 = lane1.result;

  assign ws_fwd_bus = {ws_valid && ws_bundle.lane1_valid && lane_writes(lane1),
                       lane1.dest, lane1.result,
                       ws_valid && lane_writes(lane0),
                       lane0.dest, lane0.result};

  trace_fifo_2w1r #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk   (clk),
    .reset (reset),
    .push0 (retire),
    .push1 (retire && ws_bundle.lane1_valid),
    .din0  (to_trace(lane0)),
    .din1  (to_trace(lane1)),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .count (fifo_count)
  );

  // Byte enables pulse only on the cycle an entry is presented; the rest hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else if (fifo_pop) begin
      debug_wb_pc       <= fifo_head.pc;
      debug_wb_rf_wen   <= {4{fifo_head.we}};
      debug_wb_rf_wnum  <= fifo_head.dest;
      debug_wb_rf_wdata <= fifo_head.data;
    end else begin
      debug_wb_rf_wen   <= '0;
    end
  end

endmodule
